// File: rtl/popcount_accum.sv
// popcount_accum: accumulates a frame of 2-bit popcount beats into a
// frame sum plus a beat count, then holds the result until it is taken.
//
// Configuration:
//   POPCOUNT_ACCUM_SAT_EN -- when defined, the accumulator and the registered
//                            sum clamp at 2^SUM_W-1 once the frame overflows.
//                            When undefined, they wrap modulo 2^SUM_W.
//                            In both builds, overflow reports that the frame
//                            exceeded 2^SUM_W-1.
module popcount_accum #(
   parameter int SUM_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_popcount,
   input  logic             in_last,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [SUM_W-1:0] sum,
   output logic [CNT_W-1:0] beats,
   output logic             overflow
);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   // Accumulation stage: the running totals of the frame in progress.
   logic [SUM_W-1:0] acc_p0;
   logic [CNT_W-1:0] cnt_p0;
   logic             ovf_p0;

   // Result stage: the registered totals of the last completed frame.
   logic [SUM_W-1:0] sum_p1;
   logic [CNT_W-1:0] beats_p1;
   logic             ovf_p1;

   logic             accept;
   logic [SUM_W:0]   add_full;
   logic             frame_ovf;
   logic [SUM_W-1:0] acc_upd;
   logic [CNT_W-1:0] cnt_upd;

   // Adds a zero-extended beat to the accumulator; the MSB is the carry out.
   function automatic logic [SUM_W:0] add_pop(input logic [SUM_W-1:0] a,
                                              input logic [1:0]       p);
      logic [SUM_W:0] pe;
      pe = '0;
      pe[1:0] = p;
      return {1'b0, a} + pe;
   endfunction

   // Reduces the widened addition result back to SUM_W bits, either by
   // clamping at full scale or by dropping the carry.
   function automatic logic [SUM_W-1:0] fold_sum(input logic [SUM_W:0] r,
                                                 input logic           ovf);
`ifdef POPCOUNT_ACCUM_SAT_EN
      return ovf ? {SUM_W{1'b1}} : r[SUM_W-1:0];
`else
      return (ovf && 1'b0) ? {SUM_W{1'b1}} : r[SUM_W-1:0];
`endif
   endfunction

   assign accept    = in_valid & in_ready;
   assign add_full  = add_pop(acc_p0, in_popcount);
   assign frame_ovf = ovf_p0 | add_full[SUM_W];
   assign acc_upd   = fold_sum(add_full, frame_ovf);
   assign cnt_upd   = cnt_p0 + {{(CNT_W-1){1'b0}}, 1'b1};

   // State register: reset always returns to accumulating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave ACCUM on an accepted last beat, leave HOLD on the
   // downstream handshake. sum_ready has no effect while accumulating.
   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (accept && in_last) state_nxt = HOLD;
         HOLD:    if (sum_ready)         state_nxt = ACCUM;
         default:                        state_nxt = ACCUM;
      endcase
   end

   // Outputs of the FSM: ready to take beats only while accumulating, result
   // valid only while holding. The HOLD->ACCUM edge does not also take a beat.
   always_comb begin
      in_ready  = 1'b0;
      sum_valid = 1'b0;
      case (state)
         ACCUM:   in_ready  = 1'b1;
         HOLD:    sum_valid = 1'b1;
         default: in_ready  = 1'b1;
      endcase
   end

   // Accumulation stage: fold in non-last beats, clear once the frame closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p0 <= '0;
         cnt_p0 <= '0;
         ovf_p0 <= 1'b0;
      end else if (accept) begin
         if (in_last) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            ovf_p0 <= 1'b0;
         end else begin
            acc_p0 <= acc_upd;
            cnt_p0 <= cnt_upd;
            ovf_p0 <= frame_ovf;
         end
      end
   end

   // Result stage: capture the closing totals on the last beat and hold them
   // unchanged until the next frame closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_p1   <= '0;
         beats_p1 <= '0;
         ovf_p1   <= 1'b0;
      end else if (accept && in_last) begin
         sum_p1   <= acc_upd;
         beats_p1 <= cnt_upd;
         ovf_p1   <= frame_ovf;
      end
   end

   assign sum      = sum_p1;
   assign beats    = beats_p1;
   assign overflow = ovf_p1;

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 SHALL have parameter SUM_W, default 8, giving the width of the frame sum.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the frame beat counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream popcount beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have port in_popcount, input, 2 bits: 3-bit-popcount value, 0..3.
REQ-008 SHALL have port in_last, input, 1 bit: marks the final beat of a frame.
REQ-009 SHALL have port sum_valid, output, 1 bit: frame result held and valid.
REQ-010 SHALL have port sum_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port sum, output, SUM_W bits: total ones in the frame.
REQ-012 SHALL have port beats, output, CNT_W bits: beats in the frame, modulo 2^CNT_W.
REQ-013 SHALL have port overflow, output, 1 bit: the frame sum exceeded 2^SUM_W-1.

Function
REQ-014 SHALL implement a two-state FSM: ACCUM and HOLD.
REQ-015 SHALL drive in_ready=1 in ACCUM and in_ready=0 in HOLD.
REQ-016 SHALL drive sum_valid=1 in HOLD only.
REQ-017 SHALL define a beat as accepted when in_valid & in_ready at a rising clk.
REQ-018 SHALL, on an accepted non-last beat, add in_popcount (zero-extended) to the running accumulator and increment the beat counter by 1.
REQ-019 SHALL, on an accepted beat with in_last=1, register sum = accumulator + in_popcount, beats = counter + 1 and overflow = the sticky frame-overflow flag OR the overflow of this addition.
REQ-020 SHALL, on that same edge, clear the accumulator, counter and sticky flag, and go to HOLD.
REQ-021 SHALL assert sum_valid on the cycle after the last beat is accepted (latency 1).
REQ-022 SHALL hold sum, beats and overflow stable while in HOLD.
REQ-023 SHALL, in HOLD with sum_ready=1 at a rising clk, return to ACCUM.
REQ-024 SHALL accept the next beat no earlier than the cycle after the handshake (no same-cycle bypass).
REQ-025 SHALL leave sum, beats and overflow unchanged in ACCUM until the next last beat.
REQ-026 SHALL ignore in_popcount and in_last when no beat is accepted.
REQ-027 SHALL treat a single-beat frame (in_last on the first beat) as a frame of beats=1.
REQ-028 SHALL set the sticky overflow flag when any accumulation carries out of SUM_W bits.
REQ-029 SHALL let the beat counter wrap modulo 2^CNT_W without affecting overflow.
REQ-030 SHALL ignore sum_ready while in ACCUM.

Reset
REQ-031 SHALL, while rst_n=0 and independent of clk, force state ACCUM, accumulator 0, counter 0, sticky flag 0, sum 0, beats 0 and overflow 0.
REQ-032 SHALL, during reset, drive in_ready=1 and sum_valid=0.
REQ-033 SHALL, when reset occurs mid-frame or in HOLD, discard the partial frame or pending result.

Configuration
REQ-034 SHALL, with POPCOUNT_ACCUM_SAT_EN defined, clamp the accumulator and sum at 2^SUM_W-1 once overflow occurs, with overflow=1.
REQ-035 SHALL, without POPCOUNT_ACCUM_SAT_EN, wrap the accumulator and sum modulo 2^SUM_W, with overflow=1.

Verification
REQ-036 SHALL cover: reset, then beats 3,2,1,0 with last on 0 and sum_ready=1 -> sum_valid=1 one cycle later, sum=6, beats=4, overflow=0.
REQ-037 SHALL cover: a single beat 3 with in_last=1 -> sum=3, beats=1 on the next cycle.
REQ-038 SHALL cover: sum_ready=0 for 5 cycles while in HOLD, in_valid=1 -> in_ready=0, no beat taken, sum stable, then release -> ACCUM.
REQ-039 SHALL cover: SUM_W=8, 86 beats of 3 with last -> without the macro sum=2 and overflow=1; with POPCOUNT_ACCUM_SAT_EN sum=255 and overflow=1.
REQ-040 SHALL cover: rst_n pulsed low asynchronously mid-frame after beats 3,3 -> outputs 0 immediately; next frame 1 with last -> sum=1.
REQ-041 SHALL cover: in_valid toggling with random gaps, frame 2,2,2 -> sum=6, beats=3.
